// File: rtl/mem_responder_if.sv
// Request/response bundle for mem_responder: two read ports, one masked write port, status.
// No backpressure; ready only tells the requester whether its requests are serviced.
interface mem_responder_if;
    logic        inst_en;
    logic [63:0] inst_rIdx;
    logic [63:0] inst_rdata;
    logic        data_en;
    logic [63:0] data_rIdx;
    logic [63:0] data_rdata;
    logic        wen;
    logic [63:0] wIdx;
    logic [63:0] wdata;
    logic [63:0] wmask;
    logic        ready;
    logic        err;
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;

    modport master (
        output inst_en, inst_rIdx, data_en, data_rIdx, wen, wIdx, wdata, wmask,
        input  inst_rdata, data_rdata, ready, err, rd_cnt, wr_cnt
    );
    modport slave (
        input  inst_en, inst_rIdx, data_en, data_rIdx, wen, wIdx, wdata, wmask,
        output inst_rdata, data_rdata, ready, err, rd_cnt, wr_cnt
    );
endinterface

// File: rtl/mem_responder.sv
// Word memory with two write-first read ports and a bit-masked write port; reads have 1-cycle latency.
// After reset it zeroes every word (INIT, ready=0, requests ignored), then serves every cycle without stalling.
module mem_responder #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {INIT, SERVE} state_t;

    state_t                state;
    logic [DEPTH_LOG2-1:0] clr_ptr;
    logic [63:0]           mem [DEPTH];

    logic [63:0] inst_q, data_q;
    logic        ready_q, err_q;
    logic [31:0] rd_q, wr_q;

    logic                  inst_ok, data_ok, wr_ok;
    logic [DEPTH_LOG2-1:0] inst_a, data_a, wr_a;
    logic                  serving, wr_do, inst_rd, data_rd;
    logic [63:0]           wr_word, inst_word, data_word;

    assign inst_ok = (bus.inst_rIdx >> DEPTH_LOG2) == 64'd0;
    assign data_ok = (bus.data_rIdx >> DEPTH_LOG2) == 64'd0;
    assign wr_ok   = (bus.wIdx      >> DEPTH_LOG2) == 64'd0;
    assign inst_a  = bus.inst_rIdx[DEPTH_LOG2-1:0];
    assign data_a  = bus.data_rIdx[DEPTH_LOG2-1:0];
    assign wr_a    = bus.wIdx[DEPTH_LOG2-1:0];

    assign serving = (state == SERVE);
    assign wr_do   = serving && bus.wen && wr_ok;
    assign inst_rd = serving && bus.inst_en && inst_ok;
    assign data_rd = serving && bus.data_en && data_ok;
    assign wr_word = (mem[wr_a] & ~bus.wmask) | (bus.wdata & bus.wmask);

    // A read colliding with this cycle's write sees the merged word, not the stale one.
    assign inst_word = (wr_do && wr_a == inst_a) ? wr_word : mem[inst_a];
    assign data_word = (wr_do && wr_a == data_a) ? wr_word : mem[data_a];

    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[clr_ptr] <= 64'd0;
        end else if (wr_do) begin
            mem[wr_a] <= wr_word;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= INIT;
            clr_ptr <= '0;
            inst_q  <= 64'd0;
            data_q  <= 64'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= 32'd0;
            wr_q    <= 32'd0;
        end else begin
            case (state)
                INIT: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (&clr_ptr) begin
                        state   <= SERVE;
                        ready_q <= 1'b1;
                    end
                end
                SERVE: begin
                    if (bus.inst_en) inst_q <= inst_ok ? inst_word : 64'd0;
                    if (bus.data_en) data_q <= data_ok ? data_word : 64'd0;
                    rd_q <= rd_q + 32'(inst_rd) + 32'(data_rd);
                    wr_q <= wr_q + 32'(wr_do);
                    if ((bus.inst_en && !inst_ok) || (bus.data_en && !data_ok) ||
                        (bus.wen && !wr_ok))
                        err_q <= 1'b1;
                end
                default: state <= INIT;
            endcase
        end
    end

    assign bus.inst_rdata = inst_q;
    assign bus.data_rdata = data_q;
    assign bus.ready      = ready_q;
    assign bus.err        = err_q;
    assign bus.rd_cnt     = rd_q;
    assign bus.wr_cnt     = wr_q;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder at DEPTH_LOG2=4: reference model compared every cycle, directed scenarios, random traffic.
module tb_mem_responder;
    localparam int DL = 4;
    localparam int N  = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_responder_if bus ();
    mem_responder #(.DEPTH_LOG2(DL)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: memory is all zero after N post-release edges; then writes land
    // before the same edge's reads are taken.
    logic [63:0] m_mem [N];
    int          m_left;
    logic [63:0] m_inst, m_data;
    logic        m_err;
    logic [31:0] m_rd, m_wr;

    function automatic bit inr(input logic [63:0] i);
        return i < 64'(N);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            foreach (m_mem[i]) m_mem[i] = 64'd0;
            m_left = N;
            m_inst = 64'd0;
            m_data = 64'd0;
            m_err  = 1'b0;
            m_rd   = 32'd0;
            m_wr   = 32'd0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
        end else begin
            if (bus.wen) begin
                if (inr(bus.wIdx)) begin
                    m_mem[bus.wIdx[3:0]] = (m_mem[bus.wIdx[3:0]] & ~bus.wmask) | (bus.wdata & bus.wmask);
                    m_wr = m_wr + 1;
                end else m_err = 1'b1;
            end
            if (bus.inst_en) begin
                if (inr(bus.inst_rIdx)) begin
                    m_inst = m_mem[bus.inst_rIdx[3:0]];
                    m_rd   = m_rd + 1;
                end else begin
                    m_inst = 64'd0;
                    m_err  = 1'b1;
                end
            end
            if (bus.data_en) begin
                if (inr(bus.data_rIdx)) begin
                    m_data = m_mem[bus.data_rIdx[3:0]];
                    m_rd   = m_rd + 1;
                end else begin
                    m_data = 64'd0;
                    m_err  = 1'b1;
                end
            end
        end
    end

    bit cmp_on = 1'b0;
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("inst_rdata", bus.inst_rdata, m_inst);
            chk("data_rdata", bus.data_rdata, m_data);
            chk("ready", 64'(bus.ready), 64'(m_left == 0));
            chk("err", 64'(bus.err), 64'(m_err));
            chk("rd_cnt", 64'(bus.rd_cnt), 64'(m_rd));
            chk("wr_cnt", 64'(bus.wr_cnt), 64'(m_wr));
        end
    end

    task automatic idle();
        bus.inst_en = 1'b0;
        bus.data_en = 1'b0;
        bus.wen     = 1'b0;
    endtask

    // Advance one rising edge and land 1 time unit after the following falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_inst"},  bus.inst_rdata, 64'd0);
        chk({nm, "_data"},  bus.data_rdata, 64'd0);
        chk({nm, "_ready"}, 64'(bus.ready), 64'd0);
        chk({nm, "_err"},   64'(bus.err), 64'd0);
        chk({nm, "_rd"},    64'(bus.rd_cnt), 64'd0);
        chk({nm, "_wr"},    64'(bus.wr_cnt), 64'd0);
    endtask

    task automatic wait_ready(input string nm);
        int cnt = 0;
        while (!bus.ready && cnt < 40) begin
            cyc();
            cnt++;
        end
        chk(nm, 64'(cnt), 64'd16);
    endtask

    function automatic logic [63:0] ridx();
        int unsigned r = $urandom_range(0, 19);
        if (r < 16) return 64'(r % 8);
        return {$urandom, $urandom} | 64'h10;
    endfunction

    function automatic logic [63:0] rmask();
        case ($urandom_range(0, 3))
            0:       return '1;
            1:       return 64'd0;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    logic [31:0] r0, w0;

    initial begin
        idle();
        bus.inst_rIdx = 64'd0;
        bus.data_rIdx = 64'd0;
        bus.wIdx      = 64'd0;
        bus.wdata     = 64'd0;
        bus.wmask     = 64'd0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #2 chk_all_zero("reset");
        cmp_on = 1'b1;
        cyc();
        cyc();

        // Writes held through INIT must be dropped.
        rst = 1'b1;
        bus.wen = 1'b1; bus.wIdx = 64'd0; bus.wdata = '1; bus.wmask = '1;
        wait_ready("init_cycles");
        bus.wen = 1'b0;
        bus.inst_en = 1'b1; bus.inst_rIdx = 64'd0;
        cyc();
        idle();
        chk("init_write_dropped", bus.inst_rdata, 64'd0);
        chk("init_wr_cnt", 64'(bus.wr_cnt), 64'd0);

        // Partial-mask merge.
        bus.wen = 1'b1; bus.wIdx = 64'd3; bus.wdata = 64'h1122334455667788; bus.wmask = '1;
        cyc();
        bus.wdata = 64'hFF00; bus.wmask = 64'h000000000000FF00;
        cyc();
        bus.wen = 1'b0;
        bus.data_en = 1'b1; bus.data_rIdx = 64'd3;
        cyc();
        idle();
        chk("masked_merge", bus.data_rdata, 64'h112233445566FF88);

        // Write-first on both read ports in the same cycle.
        r0 = m_rd; w0 = m_wr;
        bus.wen = 1'b1; bus.wIdx = 64'd5; bus.wdata = 64'hA5; bus.wmask = '1;
        bus.inst_en = 1'b1; bus.inst_rIdx = 64'd5;
        bus.data_en = 1'b1; bus.data_rIdx = 64'd5;
        cyc();
        idle();
        chk("wf_inst", bus.inst_rdata, 64'hA5);
        chk("wf_data", bus.data_rdata, 64'hA5);
        chk("wf_rd_cnt", 64'(bus.rd_cnt), 64'(r0 + 32'd2));
        chk("wf_wr_cnt", 64'(bus.wr_cnt), 64'(w0 + 32'd1));

        // Out-of-range read: zero data, sticky err, no count.
        r0 = m_rd;
        bus.data_en = 1'b1; bus.data_rIdx = 64'd16;
        cyc();
        idle();
        chk("oor_data", bus.data_rdata, 64'd0);
        chk("oor_err", 64'(bus.err), 64'd1);
        repeat (10) cyc();
        chk("oor_err_sticky", 64'(bus.err), 64'd1);
        chk("oor_rd_cnt", 64'(bus.rd_cnt), 64'(r0));

        // Read counter wrap.
        force dut.rd_q = 32'hFFFF_FFFE;
        release dut.rd_q;
        m_rd = 32'hFFFF_FFFE;
        bus.inst_en = 1'b1; bus.inst_rIdx = 64'd1;
        cyc();
        chk("rd_cnt_max", 64'(bus.rd_cnt), 64'hFFFF_FFFF);
        cyc();
        idle();
        chk("rd_cnt_wrap", 64'(bus.rd_cnt), 64'd0);

        // Reset mid-SERVE clears outputs immediately and re-clears memory.
        bus.wen = 1'b1; bus.wIdx = 64'd7; bus.wdata = 64'hDEAD_BEEF; bus.wmask = '1;
        cyc();
        idle();
        bus.data_en = 1'b1; bus.data_rIdx = 64'd7;
        cyc();
        idle();
        chk("pre_reset_word", bus.data_rdata, 64'hDEAD_BEEF);
        #1 rst = 1'b0;
        #1 chk_all_zero("async_reset");
        cyc();
        rst = 1'b1;
        wait_ready("reinit_cycles");
        bus.data_en = 1'b1; bus.data_rIdx = 64'd7;
        bus.inst_en = 1'b1; bus.inst_rIdx = 64'd3;
        cyc();
        idle();
        chk("reclear_7", bus.data_rdata, 64'd0);
        chk("reclear_3", bus.inst_rdata, 64'd0);

        repeat (1500) begin
            bus.wen       = ($urandom_range(0, 1) == 1);
            bus.wIdx      = ridx();
            bus.wdata     = {$urandom, $urandom};
            bus.wmask     = rmask();
            bus.inst_en   = ($urandom_range(0, 2) != 0);
            bus.inst_rIdx = ridx();
            bus.data_en   = ($urandom_range(0, 2) != 0);
            bus.data_rIdx = ridx();
            cyc();
        end
        idle();
        cyc();
        cmp_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
